// File: rtl/bcd_to_binary_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Holds the FSM state type, default sizes and BCD digit constants.
package bcd_pkg;

    localparam int DIGITS_DEF = 5;
    localparam int BIN_W_DEF  = 15;

    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VALUE  = 4'd3;
    localparam logic [3:0] MAX_DIGIT  = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ADJUST,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_to_binary_if.sv
// start/busy/done handshake bundle for the BCD-to-binary converter.
// master: start, bcd out; bin, busy, done, error in. slave: reverse.
interface bcd_to_binary_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int BIN_W  = BIN_W_DEF
);

    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start,
        output bcd,
        input  bin,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  start,
        input  bcd,
        output bin,
        output busy,
        output done,
        output error
    );

endinterface

// File: rtl/bcd_to_binary_digit_adjust.sv
// One BCD digit correction step for reverse double-dabble.
// din: 4-bit digit, dout: din-3 when din >= 8, else din.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= ADJ_THRESH) begin
            dout = din - ADJ_VALUE;
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Ports: clk, reset (sync, active-high), bus (slave: start/bcd in; bin/busy/done/error out).
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int BIN_W  = BIN_W_DEF
)(
    input  logic                 clk,
    input  logic                 reset,
    bcd_to_binary_if.slave       bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int W_W   = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [W_W-1:0]     w, w_n;
    logic [BIN_W-1:0]   bin_q, bin_n;
    logic               err_q, err_n;

    logic [BCD_W-1:0]   adj_bcd;
    logic               in_valid;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (w[BIN_W + 4*g +: 4]),
            .dout (adj_bcd[4*g +: 4])
        );
    end

    always_comb begin
        in_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd[4*i +: 4] > MAX_DIGIT) begin
                in_valid = 1'b0;
            end
        end
    end

    // bin/error are loaded on entry to DONE so they are
    // already valid during the done pulse.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        w_n     = w;
        bin_n   = bin_q;
        err_n   = err_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (in_valid) begin
                        w_n     = {bus.bcd, {BIN_W{1'b0}}};
                        cnt_n   = '0;
                        state_n = SHIFT;
                    end else begin
                        bin_n   = '0;
                        err_n   = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            SHIFT: begin
                w_n     = w >> 1;
                cnt_n   = cnt + 1'b1;
                state_n = ADJUST;
            end
            ADJUST: begin
                w_n = {adj_bcd, w[BIN_W-1:0]};
                if (cnt == CNT_LAST) begin
                    // Anything left in the BCD half means the value
                    // did not fit in BIN_W bits.
                    bin_n   = w[BIN_W-1:0];
                    err_n   = |adj_bcd;
                    state_n = DONE;
                end else begin
                    state_n = SHIFT;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            w     <= '0;
            bin_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            w     <= w_n;
            bin_q <= bin_n;
            err_q <= err_n;
        end
    end

    assign bus.bin   = bin_q;
    assign bus.error = err_q;
    assign bus.done  = (state == DONE);
    assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary.
// Vector table plus scoreboard queue, with hand-written corner sequences.
module tb_bcd_to_binary;

    typedef struct {
        logic [19:0] bcd;
        logic [14:0] bin;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [14:0] bin;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    exp_t sb[$];
    vec_t vecs[8];

    bcd_to_binary_if #(.DIGITS(5), .BIN_W(15)) bus ();

    bcd_to_binary #(.DIGITS(5), .BIN_W(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_conv(input logic [19:0] v, input logic [14:0] eb,
                            input logic ee, input int elat);
        int   n;
        exp_t e;
        n = 0;
        while (bus.busy && n < 100) begin
            step();
            n++;
        end
        bus.bcd   = v;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        sb.push_back('{bin: eb, err: ee});
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        n = 1;
        while (!bus.done && n < 100) begin
            step();
            n++;
        end
        check("latency", n, elat);
        e = sb.pop_front();
        if (bus.done) begin
            check("bin", {17'd0, bus.bin}, {17'd0, e.bin});
            check("error", {31'd0, bus.error}, {31'd0, e.err});
            check("busy_in_done", {31'd0, bus.busy}, 32'd1);
        end else begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done");
        end
        step();
        check("busy_after_done", {31'd0, bus.busy}, 32'd0);
        check("done_after_done", {31'd0, bus.done}, 32'd0);
        check("bin_held", {17'd0, bus.bin}, {17'd0, e.bin});
    endtask

    initial begin
        int   ndone;
        int   d1;
        int   d2;
        exp_t e;

        tests = 0;
        fails = 0;
        vecs[0] = '{20'h12345, 15'h3039, 1'b0, 31};
        vecs[1] = '{20'h32767, 15'h7FFF, 1'b0, 31};
        vecs[2] = '{20'h00000, 15'h0000, 1'b0, 31};
        vecs[3] = '{20'h32768, 15'h0000, 1'b1, 31};
        vecs[4] = '{20'h99999, 15'h069F, 1'b1, 31};
        vecs[5] = '{20'h1A000, 15'h0000, 1'b1, 1};
        vecs[6] = '{20'h0000A, 15'h0000, 1'b1, 1};
        vecs[7] = '{20'h09999, 15'h270F, 1'b0, 31};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.bcd   = '0;
        repeat (3) step();
        reset = 1'b0;
        check("rst_bin", {17'd0, bus.bin}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_error", {31'd0, bus.error}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].lat);
        end

        // start pulse and bcd change mid-conversion are ignored
        bus.bcd   = 20'h00042;
        bus.start = 1'b1;
        step();
        sb.push_back('{bin: 15'd42, err: 1'b0});
        ndone = 0;
        d1    = 0;
        for (int c = 1; c <= 45; c++) begin
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    d1 = c;
                    e  = sb.pop_front();
                    check("ign_bin", {17'd0, bus.bin}, {17'd0, e.bin});
                    check("ign_error", {31'd0, bus.error}, {31'd0, e.err});
                end
            end
            bus.start = (c == 10);
            if (c == 10) bus.bcd = 20'h99999;
            step();
        end
        check("ign_ndone", ndone, 1);
        check("ign_lat", d1, 31);

        // start held high re-triggers on each IDLE cycle
        bus.bcd   = 20'h00005;
        bus.start = 1'b1;
        step();
        sb.push_back('{bin: 15'd5, err: 1'b0});
        sb.push_back('{bin: 15'd5, err: 1'b0});
        ndone = 0;
        d1    = 0;
        d2    = 0;
        for (int c = 1; c <= 63; c++) begin
            if (bus.done) begin
                ndone++;
                if (ndone == 1) d1 = c;
                if (ndone == 2) d2 = c;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("hold_bin", {17'd0, bus.bin}, {17'd0, e.bin});
                end
            end
            if (c == 63) bus.start = 1'b0;
            else step();
        end
        step();
        check("hold_ndone", ndone, 2);
        check("hold_d1", d1, 31);
        check("hold_d2", d2, 63);

        // reset mid-conversion aborts with no done
        bus.bcd   = 20'h12345;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 15; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_bin", {17'd0, bus.bin}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_error", {31'd0, bus.error}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) ndone++;
            step();
        end
        check("abort_ndone", ndone, 0);
        run_conv(20'h00001, 15'd1, 1'b0, 31);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
